// File: rtl/ger16_arbiter_if.sv
// Request/response bundle between the conversion front ends, the shared regime
// generator arbiter and the posit packing stage.
interface ger16_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_exp;
  logic [N_REQ-1:0]    req_ready;
  logic                resp_valid;
  logic [ID_W-1:0]     resp_id;
  logic [15:0]         resp_regbits;
  logic                resp_ready;

  modport master (
    output req_valid, req_exp, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_regbits
  );

  modport slave (
    input  req_valid, req_exp, resp_ready,
    output req_ready, resp_valid, resp_id, resp_regbits
  );
endinterface

// File: rtl/ger16_arbiter.sv
// Round-robin arbiter feeding a two-stage 16-bit posit regime generator.
// Optional grant counter enabled by defining GER16_ARB_CNT_EN.
module ger16_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  ger16_arbiter_if.slave bus
`ifdef GER16_ARB_CNT_EN
  ,
  output logic [15:0]    grant_count
`endif
);

  // Regime bitstring of a signed exponent; the magnitude wraps so -32768 saturates.
  function automatic logic [15:0] regime_bits(input logic [15:0] e);
    logic [15:0] a;
    logic [15:0] p;
    logic [15:0] s;
    logic [15:0] h;
    a = e[15] ? (16'h0000 - e) : e;
    p = (a >= 16'd127) ? 16'h0000 : 16'h8000;
    s = $signed(p) >>> a[3:0];
    h = $signed(s) >>> 1;
    return (e[15] ? (h & ~s) : h) & 16'h7FFF;
  endfunction

  logic [ID_W-1:0]  ptr_r;
  logic             v1_r;
  logic             v2_r;
  logic [15:0]      exp1_r;
  logic [ID_W-1:0]  id1_r;
  logic [ID_W-1:0]  id2_r;
  logic [15:0]      regbits_r;

  logic             s1_adv_s;
  logic             s2_adv_s;
  logic             grant_found_s;
  logic [ID_W-1:0]  grant_idx_s;
  logic             grant_s;
  logic [N_REQ-1:0] ready_s;

  // Rotating search starting just after the last granted requester.
  always_comb begin
    int  idx;
    logic hit;
    idx           = 0;
    hit           = 1'b0;
    s2_adv_s      = !v2_r || bus.resp_ready;
    s1_adv_s      = !v1_r || s2_adv_s;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr_r) + k;
      idx = (idx >= N_REQ) ? (idx - N_REQ) : idx;
      hit = bus.req_valid[idx] && !grant_found_s;
      grant_idx_s   = hit ? ID_W'(idx) : grant_idx_s;
      grant_found_s = grant_found_s || hit;
    end
    grant_s = grant_found_s && s1_adv_s && !rst;
    ready_s = grant_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s) : {N_REQ{1'b0}};
  end

  assign bus.req_ready    = ready_s;
  assign bus.resp_valid   = v2_r;
  assign bus.resp_id      = id2_r;
  assign bus.resp_regbits = regbits_r;

  // Arbitration pointer and the two pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r     <= ID_W'(N_REQ - 1);
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      exp1_r    <= 16'h0000;
      id1_r     <= '0;
      id2_r     <= '0;
      regbits_r <= 16'h0000;
    end else begin
      if (grant_s) begin
        ptr_r <= grant_idx_s;
      end
      if (s1_adv_s) begin
        v1_r <= grant_s;
        if (grant_s) begin
          exp1_r <= bus.req_exp[16*grant_idx_s +: 16];
          id1_r  <= grant_idx_s;
        end
      end
      // S2 loads whenever it can move; an empty S1 leaves a bubble behind.
      if (s2_adv_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          regbits_r <= regime_bits(exp1_r);
          id2_r     <= id1_r;
        end
      end
    end
  end

`ifdef GER16_ARB_CNT_EN
  logic [15:0] grant_count_r;

  // Free-running count of accepted requests, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count_r <= 16'h0000;
    end else if (grant_s) begin
      grant_count_r <= grant_count_r + 16'h0001;
    end else begin
      grant_count_r <= grant_count_r;
    end
  end

  assign grant_count = grant_count_r;
`endif

endmodule
